// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB packet transmit sequencer.
// Holds the FSM encoding, the CRC-16/USB parameters and the data PIDs.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    PID  = 3'b001,
    DATA = 3'b010,
    CRC1 = 3'b011,
    CRC2 = 3'b100
  } state_t;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  localparam logic [3:0] DATA0 = 4'b0011;
  localparam logic [3:0] DATA1 = 4'b1011;

endpackage

// File: rtl/usb_tx_pkt_seq_if.sv
// Byte streams around the sequencer: upstream payload in, PHY-side bytes out.
// The master modport is the sequencer's view.
interface usb_tx_pkt_seq_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  in_data, in_valid, tx_ready,
    output in_ready, tx_data, tx_valid
  );

  modport slave (
    output in_data, in_valid, tx_ready,
    input  in_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/usb_crc16_upd.sv
// One-byte update of the reflected CRC-16/USB register (poly 0xA001, LSB first).
module usb_crc16_upd
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // NOTE: blocking assignments here chain the eight shift steps combinationally.
  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_pkt_seq.sv
// USB packet transmit sequencer: PID byte, streamed payload, complemented CRC16,
// all over a valid/ready link, plus a shift history of tx_valid.
module usb_tx_pkt_seq
  import usb_tx_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int HIST_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send_data,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [3:0]        pid,
  usb_tx_pkt_seq_if.master  bus,
  output logic              busy,
  output logic              pkt_done,
  output logic              len_err,
  output logic [HIST_W-1:0] buff
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] count, count_nxt;
  logic [15:0]      crc, crc_nxt, crc_upd;
  logic [3:0]       pid_q, pid_nxt;
  logic             pkt_done_nxt, len_err_nxt;

  usb_crc16_upd u_crc (
    .crc_in  (crc),
    .data    (bus.in_data),
    .crc_out (crc_upd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      crc      <= CRC16_INIT;
      pid_q    <= '0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      buff     <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      crc      <= crc_nxt;
      pid_q    <= pid_nxt;
      pkt_done <= pkt_done_nxt;
      len_err  <= len_err_nxt;
      buff     <= {buff[HIST_W-2:0], bus.tx_valid};
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    crc_nxt      = crc;
    pid_nxt      = pid_q;
    pkt_done_nxt = 1'b0;
    len_err_nxt  = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.in_ready = 1'b0;
    busy         = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (send_data) begin
          if (pkt_len > LEN_W'(MAX_LEN)) begin
            len_err_nxt = 1'b1;
          end else begin
            count_nxt = pkt_len;
            pid_nxt   = pid;
            crc_nxt   = CRC16_INIT;
            state_nxt = PID;
          end
        end
      end
      PID: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {~pid_q, pid_q};
        if (bus.tx_ready) state_nxt = (count != '0) ? DATA : CRC1;
      end
      DATA: begin
        // Pass-through: upstream stalls and PHY back-pressure propagate directly.
        bus.tx_data  = bus.in_data;
        bus.tx_valid = bus.in_valid;
        bus.in_ready = bus.tx_ready;
        if (bus.in_valid && bus.tx_ready) begin
          crc_nxt   = crc_upd;
          count_nxt = count - LEN_W'(1);
          if (count == LEN_W'(1)) state_nxt = CRC1;
        end
      end
      CRC1: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = ~crc[7:0];
        if (bus.tx_ready) state_nxt = CRC2;
      end
      CRC2: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = ~crc[15:8];
        if (bus.tx_ready) begin
          state_nxt    = IDLE;
          pkt_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_pkt_seq.sv
// Self-checking bench for usb_tx_pkt_seq: directed and random packets compared
// with a bit-serial CRC-16/USB model and an expected byte queue.
module tb_usb_tx_pkt_seq;
  import usb_tx_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int HIST_W  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              send_data;
  logic [LEN_W-1:0]  pkt_len;
  logic [3:0]        pid;
  logic              busy, pkt_done, len_err;
  logic [HIST_W-1:0] buff;

  usb_tx_pkt_seq_if bus ();

  usb_tx_pkt_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .HIST_W(HIST_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .send_data (send_data),
    .pkt_len   (pkt_len),
    .pid       (pid),
    .bus       (bus.master),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .len_err   (len_err),
    .buff      (buff)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [HIST_W-1:0] hist;
  logic [7:0] payload [0:MAX_LEN-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the history, commit one clock edge, then advance to the next sample point.
  task automatic tick(input logic ev);
    check("buff", 32'(buff), 32'(hist));
    @(posedge clk);
    hist = reset ? {hist[HIST_W-2:0], ev} : '0;
    @(negedge clk);
  endtask

  // Bit-serial CRC-16/USB over the first n payload bytes (register before complement).
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ payload[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  // vmode: 0 in_valid always, 1 random, 2 pattern 1,1,0. rmode: 0 tx_ready always, 1 random.
  task automatic run_pkt(input logic [3:0] p, input int len, input int vmode, input int rmode);
    logic [7:0]  exp_q[$];
    logic [15:0] c;
    int          nbeats, bi, di, cyc;
    bit          data_ph;
    logic        ev;

    exp_q.push_back({~p, p});
    for (int i = 0; i < len; i++) exp_q.push_back(payload[i]);
    c = crc_ref(len);
    exp_q.push_back(~c[7:0]);
    exp_q.push_back(~c[15:8]);
    nbeats = len + 3;

    send_data = 1'b1;
    pkt_len   = LEN_W'(len);
    pid       = p;
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b0;
    #1;
    check("req_busy", 32'(busy), 0);
    tick(1'b0);
    send_data = 1'b0;
    pkt_len   = LEN_W'($urandom_range(0, MAX_LEN));
    pid       = 4'($urandom);

    bi = 0; di = 0; cyc = 0;
    while (bi < nbeats && cyc < 4000) begin
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = ($urandom_range(0, 2) != 0);
        default: bus.in_valid = ((cyc % 3) != 2);
      endcase
      bus.tx_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.in_data  = (di < len) ? payload[di] : 8'($urandom);
      #1;
      data_ph = (bi >= 1) && (bi <= len);
      ev = data_ph ? bus.in_valid : 1'b1;
      check("busy", 32'(busy), 1);
      check("pkt_done_low", 32'(pkt_done), 0);
      check("tx_valid", 32'(bus.tx_valid), 32'(ev));
      check("in_ready", 32'(bus.in_ready), data_ph ? 32'(bus.tx_ready) : 0);
      if (!data_ph) check("ctl_byte", 32'(bus.tx_data), 32'(exp_q[bi]));
      if (ev && bus.tx_ready) begin
        check("tx_data", 32'(bus.tx_data), 32'(exp_q[bi]));
        bi++;
        if (data_ph) di++;
      end
      tick(ev);
      cyc++;
    end
    check("pkt_beats", 32'(bi), 32'(nbeats));

    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b0;
    #1;
    check("pkt_done", 32'(pkt_done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_tx_valid", 32'(bus.tx_valid), 0);
    check("done_tx_data", 32'(bus.tx_data), 0);
  endtask

  initial begin
    reset = 1'b0; send_data = 1'b0; pkt_len = '0; pid = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.tx_ready = 1'b0;
    hist = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_pkt_done", 32'(pkt_done), 0);
    check("rst_len_err", 32'(len_err), 0);
    check("rst_buff", 32'(buff), 0);
    tick(1'b0);

    // Directed 9-byte DATA0 packet, then back-to-back zero-length DATA1.
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
    run_pkt(DATA0, 9, 0, 0);
    run_pkt(DATA1, 0, 0, 0);
    tick(1'b0);
    check("idle_pkt_done", 32'(pkt_done), 0);

    // Same packet with random stalls on both sides.
    run_pkt(DATA0, 9, 1, 1);
    tick(1'b0);

    // Random payloads and lengths, including the maximum.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < MAX_LEN; i++) payload[i] = 8'($urandom);
      run_pkt(4'($urandom), int'($urandom_range(1, MAX_LEN)), 1, 1);
      tick(1'b0);
    end
    run_pkt(DATA1, MAX_LEN, 1, 1);
    tick(1'b0);

    // tx_valid pattern 1,1,0 through the DATA pass-through.
    run_pkt(DATA0, 9, 2, 0);
    tick(1'b0);

    // Oversize request rejected.
    send_data = 1'b1; pkt_len = LEN_W'(MAX_LEN + 1); pid = DATA0;
    #1;
    tick(1'b0);
    send_data = 1'b0;
    #1;
    check("len_err_pulse", 32'(len_err), 1);
    check("len_err_busy", 32'(busy), 0);
    tick(1'b0);
    check("len_err_low", 32'(len_err), 0);
    check("len_err_busy2", 32'(busy), 0);
    tick(1'b0);

    // Reset during DATA byte 4 abandons the packet.
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
    send_data = 1'b1; pkt_len = 7'd9; pid = DATA0;
    bus.in_valid = 1'b1; bus.tx_ready = 1'b1;
    #1;
    tick(1'b0);
    send_data = 1'b0;
    #1;
    check("abort_pid", 32'(bus.tx_data), 32'h0000_00C3);
    tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.in_data = payload[i];
      #1;
      tick(1'b1);
    end
    bus.in_data = payload[4];
    reset = 1'b0;
    #1;
    check("abort_byte4", 32'(bus.tx_data), 32'h0000_0035);
    tick(1'b1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_buff", 32'(buff), 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_tx_valid", 32'(bus.tx_valid), 0);
      check("abort_in_ready", 32'(bus.in_ready), 0);
      check("abort_pkt_done", 32'(pkt_done), 0);
      tick(1'b0);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
